mem_sram_ctrl: RTL and testbench

Memory-stage controller sitting directly downstream of the EXE/MEM pipeline register. It consumes the registered memory request (`MEM_R_EN`/`MEM_W_EN`, `ALURes` as address, `valRm` as store data) and performs one 32-bit load or store on a 256K×16 asynchronous SRAM as two 16-bit half-word accesses with programmable wait states. While an access is in flight it raises `freeze` to stall the pipeline, then presents `memRes` to the MEM/WB stage.

---
 rtl/mem_sram_ctrl_if.sv | 52 +++++
 rtl/mem_sram_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_sram_ctrl_if
//
// Purpose: groups the pipeline-side request/response signals of the
// memory-stage SRAM controller.
//
// Signals:
//   MEM_R_EN  load request (level) from the EXE/MEM register
//   MEM_W_EN  store request (level) from the EXE/MEM register
//   ALURes    byte address of the access
//   valRm     store data
//   memRes    registered load result
//   ready     high when nothing is pending or the access completes this cycle
//   freeze    ~ready, stalls the upstream pipeline registers
//   addr_err  one-cycle pulse on an out-of-range access
//
// Modports:
//   master  pipeline side (drives the request, observes the response)
//   slave   controller side
// -----------------------------------------------------------------------------
interface mem_sram_ctrl_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALURes;
    logic [31:0] valRm;
    logic [31:0] memRes;
    logic        ready;
    logic        freeze;
    logic        addr_err;

    modport master (
        output MEM_R_EN,
        output MEM_W_EN,
        output ALURes,
        output valRm,
        input  memRes,
        input  ready,
        input  freeze,
        input  addr_err
    );

    modport slave (
        input  MEM_R_EN,
        input  MEM_W_EN,
        input  ALURes,
        input  valRm,
        output memRes,
        output ready,
        output freeze,
        output addr_err
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_sram_ctrl
//
// Purpose: memory-stage controller placed after the EXE/MEM register. Performs
// one 32-bit load or store on a 256Kx16 asynchronous SRAM as two 16-bit
// half-word phases (LO then HI), each lasting WAIT_CYCLES clocks. While the
// access is in flight, freeze stalls the pipeline.
//
// Parameters:
//   WAIT_CYCLES  clocks per half-word phase (1..15)
//   BASE_ADDR    byte address mapped to SRAM word 0
//
// Optional feature (compile-time macro MEM_RANGE_CHECK_EN):
//   defined   - accesses below BASE_ADDR or with offset >= 2^19 skip the SRAM,
//               go straight to DONE, pulse addr_err and return 0 on a read.
//   undefined - no check; the offset wraps modulo 2^19, addr_err tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          pipeline request/response (mem_sram_ctrl_if.slave)
//   SRAM_DQ      16-bit bidirectional SRAM data bus
//   SRAM_ADDR    18-bit SRAM half-word address (registered)
//   SRAM_WE_N    write strobe, active-low (registered)
//   SRAM_OE_N    output enable, active-low (registered)
//   SRAM_CE_N    chip enable, tied active
//   SRAM_UB_N    upper byte enable, tied active
//   SRAM_LB_N    lower byte enable, tied active
//   o_dbg_state  current FSM state (0 IDLE, 1 LO, 2 HI, 3 DONE)
//
// Handshake: a request is a level on MEM_R_EN/MEM_W_EN. The controller accepts
// it in IDLE and holds ready low until the access reaches DONE; ready=1 in DONE
// means the result is final and the upstream registers advance at the end of
// that cycle. The request must stay stable while ready is low, which the
// frozen upstream register guarantees.
// -----------------------------------------------------------------------------
module mem_sram_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    mem_sram_ctrl_if.slave bus,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;
    logic [15:0] r_lo;
    logic [31:0] r_memres;
    logic [17:0] r_sram_addr;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_dq_oe;
    logic [15:0] r_dq_out;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic        w_req;
    logic        w_last;
    logic        w_ready;
    logic        w_oor;
    logic [31:0] w_off;
    logic [16:0] w_word;

    assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
    assign w_last = (r_cnt == LAST_CNT);
    assign w_off  = bus.ALURes - BASE_ADDR;
    assign w_word = w_off[18:2];

`ifdef MEM_RANGE_CHECK_EN
    logic r_addr_err;
    logic w_unused_off;

    // Below the base the subtraction wraps, so the compare is needed in
    // addition to the upper-bit test on the offset.
    assign w_oor        = (bus.ALURes < BASE_ADDR) || (w_off[31:19] != 13'd0);
    assign w_unused_off = &{1'b0, w_off[1:0]};
    assign bus.addr_err = r_addr_err;
`else
    logic w_unused_off;

    // Without the check the offset simply wraps modulo 2^19.
    assign w_oor        = 1'b0;
    assign w_unused_off = &{1'b0, w_off[1:0], w_off[31:19]};
    assign bus.addr_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_oor ? S_DONE : S_LO;
                end else begin
                    w_ready = 1'b1;
                end
            end
            S_LO: begin
                if (w_last) begin
                    w_state_nxt = S_HI;
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Nothing is pending while the block is held in reset, so the
        // pipeline is never frozen by a request that cannot be served.
        if (!rst) begin
            w_ready = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter: counts clocks within LO and HI, cleared elsewhere.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if ((r_state == S_LO) || (r_state == S_HI)) begin
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Request latch, SRAM strobes/address/data and load result.
    // All SRAM-facing signals are registered so they only change on clock
    // edges and stay constant across a whole phase. The values for the next
    // phase are loaded on the edge that enters it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write     <= 1'b0;
            r_word      <= 17'd0;
            r_wdata_hi  <= 16'd0;
            r_lo        <= 16'd0;
            r_memres    <= 32'd0;
            r_sram_addr <= 18'd0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= 16'd0;
`ifdef MEM_RANGE_CHECK_EN
            r_addr_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Both enables high counts as a store.
                        r_write    <= bus.MEM_W_EN;
                        r_word     <= w_word;
                        r_wdata_hi <= bus.valRm[31:16];
                        if (!w_oor) begin
                            r_sram_addr <= {w_word, 1'b0};
                            r_we_n      <= ~bus.MEM_W_EN;
                            r_oe_n      <= bus.MEM_W_EN;
                            r_dq_oe     <= bus.MEM_W_EN;
                            r_dq_out    <= bus.valRm[15:0];
                        end
`ifdef MEM_RANGE_CHECK_EN
                        else begin
                            r_addr_err <= 1'b1;
                            if (!bus.MEM_W_EN) begin
                                r_memres <= 32'd0;
                            end
                        end
`endif
                    end
                end
                S_LO: begin
                    if (w_last) begin
                        if (!r_write) begin
                            r_lo <= SRAM_DQ;
                        end
                        r_sram_addr <= {r_word, 1'b1};
                        r_dq_out    <= r_wdata_hi;
                    end
                end
                S_HI: begin
                    if (w_last) begin
                        // The high half is sampled on the same edge that
                        // enters DONE so the full word is visible in DONE.
                        if (!r_write) begin
                            r_memres <= {SRAM_DQ, r_lo};
                        end
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                    end
                end
                S_DONE: begin
`ifdef MEM_RANGE_CHECK_EN
                    r_addr_err <= 1'b0;
`endif
                end
                default: begin
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SRAM_DQ     = r_dq_oe ? r_dq_out : 16'hzzzz;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;

    assign bus.memRes  = r_memres;
    assign bus.ready   = w_ready;
    assign bus.freeze  = ~w_ready;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_sram_ctrl
//
// Directed bench for mem_sram_ctrl with WAIT_CYCLES=2, BASE_ADDR=1024, and a
// small behavioural async SRAM model (1K half-words, indexed by SRAM_ADDR[9:0]).
// -----------------------------------------------------------------------------
module tb_mem_sram_ctrl;

    localparam int WAIT = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    mem_sram_ctrl_if bus ();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [1:0]  dbg_state;

    mem_sram_ctrl #(
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .SRAM_DQ     (sram_dq),
        .SRAM_ADDR   (sram_addr),
        .SRAM_WE_N   (sram_we_n),
        .SRAM_OE_N   (sram_oe_n),
        .SRAM_CE_N   (sram_ce_n),
        .SRAM_UB_N   (sram_ub_n),
        .SRAM_LB_N   (sram_lb_n),
        .o_dbg_state (dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [15:0] mem [0:1023];

    assign sram_dq = (!sram_oe_n && sram_we_n && !sram_ce_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n && !sram_ce_n) begin
            mem[sram_addr[9:0]] <= sram_dq;
        end
    end

    // ---------------- activity monitor ----------------
    int          strobe_cnt;
    int          err_cnt;
    logic [17:0] first_addr;

    always @(negedge clk) begin
        if (!sram_we_n || !sram_oe_n) begin
            if (strobe_cnt == 0) first_addr = sram_addr;
            strobe_cnt++;
        end
        if (bus.addr_err) err_cnt++;
    end

    // ---------------- scoreboard counters ----------------
    int n_checks;
    int n_fail;

    // ---------------- driver ----------------
    // Presents one request, counts consecutive freeze cycles, and returns the
    // memRes value seen in the DONE cycle. Request is dropped after DONE.
    task automatic do_access(input logic we, input logic re,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int frz, output logic [31:0] res);
        bit tmo;
        @(posedge clk);
        #1;
        bus.MEM_W_EN = we;
        bus.MEM_R_EN = re;
        bus.ALURes   = addr;
        bus.valRm    = data;
        frz = 0;
        tmo = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.freeze) begin
                frz++;
            end else begin
                tmo = 1'b0;
                break;
            end
        end
        res = bus.memRes;
        n_checks++;
        if (tmo) begin
            n_fail++;
            $display("FAIL access_timeout: addr=%h freeze still %b after 64 cycles, required 0", addr, bus.freeze);
        end
        @(posedge clk);
        #1;
        bus.MEM_W_EN = 1'b0;
        bus.MEM_R_EN = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit tmo;
        rst          = 1'b0;
        bus.MEM_W_EN = 1'b1;
        bus.MEM_R_EN = 1'b0;
        bus.ALURes   = 32'd1088;
        bus.valRm    = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sram_we_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_we_n: got %b required 1", sram_we_n);
        end
        n_checks++;
        if (sram_oe_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_oe_n: got %b required 1", sram_oe_n);
        end
        n_checks++;
        if (dut.r_dq_oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_dq_driven: got %b required 0", dut.r_dq_oe);
        end
        n_checks++;
        if (bus.memRes !== 32'd0) begin
            n_fail++; $display("FAIL reset_memres: got %h required 0", bus.memRes);
        end
        n_checks++;
        if (bus.ready !== 1'b1 || bus.addr_err !== 1'b0 || sram_addr !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_ready_err_addr: got ready=%b err=%b addr=%h required 1 0 0",
                     bus.ready, bus.addr_err, sram_addr);
        end
        // Release just after an edge: the held store starts on the next edge.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (dbg_state !== 2'd1 || sram_we_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_start: got state=%0d we_n=%b required 1 0", dbg_state, sram_we_n);
        end
        tmo = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                tmo = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.MEM_W_EN = 1'b0;
        n_checks++;
        if (tmo || mem[32] !== 16'hF00D || mem[33] !== 16'hCAFE) begin
            n_fail++;
            $display("FAIL reset_release_store: tmo=%b mem32=%h mem33=%h required 0 F00D CAFE",
                     tmo, mem[32], mem[33]);
        end
    endtask

    task automatic test_store();
        int          frz;
        logic [31:0] res;
        do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, frz, res);
        n_checks++;
        if (frz !== 1 + 2 * WAIT) begin
            n_fail++; $display("FAIL store_freeze: got %0d cycles required %0d", frz, 1 + 2 * WAIT);
        end
        n_checks++;
        if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
            n_fail++; $display("FAIL store_data: got hw2=%h hw3=%h required BEEF DEAD", mem[2], mem[3]);
        end
        n_checks++;
        if (res !== 32'd0) begin
            n_fail++; $display("FAIL store_memres_kept: got %h required 0", res);
        end
    endtask

    task automatic test_load();
        int          frz;
        logic [31:0] res;
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, frz, res);
        n_checks++;
        if (frz !== 1 + 2 * WAIT) begin
            n_fail++; $display("FAIL load_freeze: got %0d cycles required %0d", frz, 1 + 2 * WAIT);
        end
        n_checks++;
        if (res !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_data: got %h required DEADBEEF", res);
        end
    endtask

    task automatic test_both_enables();
        int          frz;
        logic [31:0] res;
        // Bits [1:0] of the address are ignored.
        do_access(1'b1, 1'b1, 32'd1039, 32'h12345678, frz, res);
        n_checks++;
        if (mem[6] !== 16'h5678 || mem[7] !== 16'h1234) begin
            n_fail++; $display("FAIL both_en_write: got hw6=%h hw7=%h required 5678 1234", mem[6], mem[7]);
        end
        n_checks++;
        if (res !== 32'hDEADBEEF || frz !== 1 + 2 * WAIT) begin
            n_fail++; $display("FAIL both_en_memres: got %h frz=%0d required DEADBEEF 5", res, frz);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || dut.r_dq_oe !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL idle_quiet: got %0d bad cycles of 10 required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] pat;
        logic [31:0] res0;
        logic [31:0] res1;
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[4] = 16'h5555;
        mem[5] = 16'h6666;
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b1;
        bus.ALURes   = 32'd1024;
        res0 = '0;
        res1 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[11 - i] = bus.freeze;
            if (i == 5) begin
                res0 = bus.memRes;
                @(posedge clk);
                #1;
                bus.ALURes = 32'd1032;
            end
            if (i == 11) res1 = bus.memRes;
        end
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b0;
        n_checks++;
        if (pat !== 12'b111110_111110) begin
            n_fail++; $display("FAIL b2b_freeze_pattern: got %b required 111110111110", pat);
        end
        n_checks++;
        if (res0 !== 32'h22221111) begin
            n_fail++; $display("FAIL b2b_first: got %h required 22221111", res0);
        end
        n_checks++;
        if (res1 !== 32'h66665555) begin
            n_fail++; $display("FAIL b2b_second: got %h required 66665555", res1);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        bus.MEM_R_EN = 1'b1;
        bus.ALURes   = 32'd1024;
        // Edges: ->LO, LO, ->HI, HI (last HI cycle).
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (dbg_state !== 2'd2 || sram_oe_n !== 1'b0) begin
            n_fail++; $display("FAIL mid_in_hi: got state=%0d oe_n=%b required 2 0", dbg_state, sram_oe_n);
        end
        #1;
        rst          = 1'b0;
        bus.MEM_R_EN = 1'b0;
        #1;
        n_checks++;
        if (dbg_state !== 2'd0 || bus.memRes !== 32'd0) begin
            n_fail++; $display("FAIL mid_abort: got state=%0d memRes=%h required 0 0", dbg_state, bus.memRes);
        end
        n_checks++;
        if (sram_oe_n !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'd0) begin
            n_fail++;
            $display("FAIL mid_strobes: got oe_n=%b we_n=%b addr=%h required 1 1 0", sram_oe_n, sram_we_n, sram_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dbg_state !== 2'd0 || bus.ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_after_release: got state=%0d ready=%b required 0 1", dbg_state, bus.ready);
        end
    endtask

    task automatic test_range();
        int          frz;
        logic [31:0] res;
`ifdef MEM_RANGE_CHECK_EN
        strobe_cnt = 0;
        err_cnt    = 0;
        do_access(1'b0, 1'b1, 32'd16, 32'h0, frz, res);
        repeat (2) @(negedge clk);
        n_checks++;
        if (frz !== 1) begin
            n_fail++; $display("FAIL range_freeze: got %0d cycles required 1", frz);
        end
        n_checks++;
        if (err_cnt !== 1) begin
            n_fail++; $display("FAIL range_err_pulse: got %0d cycles required 1", err_cnt);
        end
        n_checks++;
        if (res !== 32'd0 || strobe_cnt !== 0) begin
            n_fail++; $display("FAIL range_no_access: got memRes=%h strobes=%0d required 0 0", res, strobe_cnt);
        end
`else
        // 16 - 1024 wraps: off[18:0]=0x7FC10, word 0x1FF04, half-word 0x3FE08.
        mem[520] = 16'hAAAA;
        mem[521] = 16'hBBBB;
        strobe_cnt = 0;
        err_cnt    = 0;
        do_access(1'b0, 1'b1, 32'd16, 32'h0, frz, res);
        repeat (2) @(negedge clk);
        n_checks++;
        if (frz !== 1 + 2 * WAIT || err_cnt !== 0) begin
            n_fail++; $display("FAIL wrap_freeze_err: got frz=%0d err=%0d required 5 0", frz, err_cnt);
        end
        n_checks++;
        if (first_addr !== 18'h3FE08) begin
            n_fail++; $display("FAIL wrap_addr: got %h required 3FE08", first_addr);
        end
        n_checks++;
        if (res !== 32'hBBBBAAAA) begin
            n_fail++; $display("FAIL wrap_data: got %h required BBBBAAAA", res);
        end
`endif
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        strobe_cnt   = 0;
        err_cnt      = 0;
        first_addr   = '0;
        rst          = 1'b0;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.ALURes   = 32'd0;
        bus.valRm    = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

        test_reset();
        test_store();
        test_load();
        test_both_enables();
        test_idle();
        test_back_to_back();
        test_reset_mid();
        test_range();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
